fetch_decode_buffer: RTL

- Receiving end of the instruction-fetch interface. Consumes one 16-bit word per cycle plus its PC values from the fetch stage.
- Pairs two-word instructions (opcode word followed by a 16-bit immediate word) into one decode packet.
- Presents a registered IF/ID packet to the decode stage and honours the pipeline stall and flush controls.

---
 rtl/fetch_decode_buffer_if.sv | 27 ++
 rtl/fetch_decode_buffer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-to-decode bundle: one fetched word with its PC pair in, one IF/ID packet out.
// The master modport is the fetch side; the slave modport is the buffer.
interface fetch_decode_buffer_if #(
  parameter int PC_W = 32
);
  logic            fetch_valid;
  logic [15:0]     fetch_word;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] fetch_next_pc;

  logic            id_valid;
  logic [15:0]     id_instruction;
  logic [15:0]     id_immediate;
  logic            id_has_imm;
  logic [PC_W-1:0] id_pc;
  logic [PC_W-1:0] id_next_pc;

  modport master (
    output fetch_valid, fetch_word, fetch_pc, fetch_next_pc,
    input  id_valid, id_instruction, id_immediate, id_has_imm, id_pc, id_next_pc
  );

  modport slave (
    input  fetch_valid, fetch_word, fetch_pc, fetch_next_pc,
    output id_valid, id_instruction, id_immediate, id_has_imm, id_pc, id_next_pc
  );
endinterface

// File: rtl/fetch_decode_buffer.sv
// IF/ID buffer: pairs opcode+immediate words into one registered decode packet.
// Optional FD_BUF_PERF_EN adds issued-instruction and bubble counters.
module fetch_decode_buffer #(
  parameter int          IMM_FLAG_BIT = 15,
  parameter logic [15:0] NOP_WORD     = 16'h0000,
  parameter int          PC_W         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  fetch_decode_buffer_if.slave   bus,
`ifdef FD_BUF_PERF_EN
  output logic [31:0]            perf_instr_cnt,
  output logic [31:0]            perf_bubble_cnt,
`endif
  output logic                   imm_pending
);

  typedef enum logic {S_FIRST = 1'b0, S_IMM = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [15:0]     hold_word_q, hold_word_d;
  logic [PC_W-1:0] hold_pc_q, hold_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [15:0]     id_instruction_q, id_instruction_d;
  logic [15:0]     id_immediate_q, id_immediate_d;
  logic            id_has_imm_q, id_has_imm_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  logic [PC_W-1:0] id_next_pc_q, id_next_pc_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d          = state_q;
    hold_word_d      = hold_word_q;
    hold_pc_d        = hold_pc_q;
    id_valid_d       = id_valid_q;
    id_instruction_d = id_instruction_q;
    id_immediate_d   = id_immediate_q;
    id_has_imm_d     = id_has_imm_q;
    id_pc_d          = id_pc_q;
    id_next_pc_d     = id_next_pc_q;

    if (flush) begin
      // Flush outranks stall: the held opcode and the word on the bus both die.
      state_d          = S_FIRST;
      id_valid_d       = 1'b0;
      id_instruction_d = NOP_WORD;
      id_immediate_d   = '0;
      id_has_imm_d     = 1'b0;
    end else if (!stall) begin
      id_valid_d       = 1'b0;
      id_instruction_d = NOP_WORD;
      id_immediate_d   = '0;
      id_has_imm_d     = 1'b0;
      if (bus.fetch_valid) begin
        unique case (state_q)
          S_FIRST: begin
            if (bus.fetch_word[IMM_FLAG_BIT]) begin
              hold_word_d = bus.fetch_word;
              hold_pc_d   = bus.fetch_pc;
              state_d     = S_IMM;
            end else begin
              id_valid_d       = 1'b1;
              id_instruction_d = bus.fetch_word;
              id_pc_d          = bus.fetch_pc;
              id_next_pc_d     = bus.fetch_next_pc;
            end
          end
          S_IMM: begin
            // Second word is pure data; its flag bit is deliberately ignored.
            id_valid_d       = 1'b1;
            id_instruction_d = hold_word_q;
            id_immediate_d   = bus.fetch_word;
            id_has_imm_d     = 1'b1;
            id_pc_d          = hold_pc_q;
            id_next_pc_d     = bus.fetch_next_pc;
            state_d          = S_FIRST;
          end
          default: state_d = S_FIRST;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_FIRST;
      hold_word_q      <= '0;
      hold_pc_q        <= '0;
      id_valid_q       <= 1'b0;
      id_instruction_q <= NOP_WORD;
      id_immediate_q   <= '0;
      id_has_imm_q     <= 1'b0;
      id_pc_q          <= '0;
      id_next_pc_q     <= '0;
    end else begin
      state_q          <= state_d;
      hold_word_q      <= hold_word_d;
      hold_pc_q        <= hold_pc_d;
      id_valid_q       <= id_valid_d;
      id_instruction_q <= id_instruction_d;
      id_immediate_q   <= id_immediate_d;
      id_has_imm_q     <= id_has_imm_d;
      id_pc_q          <= id_pc_d;
      id_next_pc_q     <= id_next_pc_d;
    end
  end

  assign bus.id_valid       = id_valid_q;
  assign bus.id_instruction = id_instruction_q;
  assign bus.id_immediate   = id_immediate_q;
  assign bus.id_has_imm     = id_has_imm_q;
  assign bus.id_pc          = id_pc_q;
  assign bus.id_next_pc     = id_next_pc_q;
  assign imm_pending        = (state_q == S_IMM);

`ifdef FD_BUF_PERF_EN
  logic [31:0] perf_instr_q, perf_instr_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  // A flush is counted as a bubble even when stall is also high.
  always_comb begin
    perf_instr_d  = perf_instr_q;
    perf_bubble_d = perf_bubble_q;
    if (!flush && !stall && id_valid_d) perf_instr_d  = perf_instr_q + 32'd1;
    if (flush || (!stall && !id_valid_d)) perf_bubble_d = perf_bubble_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_instr_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_instr_q  <= perf_instr_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_instr_cnt  = perf_instr_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule
